// File: rtl/rw_responder_pkg.sv
// Shared constants and throttle-state encoding for the Read/Write strobe responder.
package rw_responder_pkg;

  typedef enum logic {
    ST_NORMAL   = 1'b0,
    ST_THROTTLE = 1'b1
  } thr_state_e;

  localparam int DEF_DATA_W = 8;
  localparam int DEF_DEPTH  = 4;

endpackage

// File: rtl/rw_buf_mem.sv
// DEPTH x DATA_W register array: one write port, one registered read port.
module rw_buf_mem
  import rw_responder_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int DEPTH  = DEF_DEPTH,
  parameter int ADDR_W = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] mem_d [DEPTH];
  logic [DATA_W-1:0] rdata_q;
  logic [DATA_W-1:0] rdata_d;

  always_comb begin
    mem_d   = mem_q;
    rdata_d = rdata_q;
    if (we) mem_d[waddr] = wdata;
    if (re) rdata_d = mem_q[raddr];
  end

  // Storage is deliberately left out of reset; only the read register clears.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
    if (rst) rdata_q <= '0;
    else     rdata_q <= rdata_d;
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/rw_responder.sv
// Target-side responder: services Read/Write strobes against a circular buffer
// and raises Slowrun with hysteresis as the buffer fills.
module rw_responder
  import rw_responder_pkg::*;
#(
  parameter int DATA_W    = DEF_DATA_W,
  parameter int DEPTH     = DEF_DEPTH,
  parameter int ADDR_W    = 2,
  parameter int HI_THRESH = 3,
  parameter int LO_THRESH = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              Read,
  input  logic              Write,
  input  logic [DATA_W-1:0] WData,
  output logic [DATA_W-1:0] RData,
  output logic              RValid,
  output logic              Slowrun,
  output logic              Full,
  output logic              Empty,
  output logic [ADDR_W:0]   Count,
  output logic              Overrun,
  output logic              Underrun
);

  localparam logic [ADDR_W:0] DEPTH_C = DEPTH[ADDR_W:0];
  localparam logic [ADDR_W:0] HI_C    = HI_THRESH[ADDR_W:0];
  localparam logic [ADDR_W:0] LO_C    = LO_THRESH[ADDR_W:0];

  logic [ADDR_W-1:0] wptr_q, wptr_d;
  logic [ADDR_W-1:0] rptr_q, rptr_d;
  logic [ADDR_W:0]   count_q, count_d;
  logic              rvalid_q, rvalid_d;
  logic              overrun_q, overrun_d;
  logic              underrun_q, underrun_d;
  thr_state_e        state_q, state_d;

  logic full, empty, wr_acc, rd_acc;

  assign full   = (count_q == DEPTH_C);
  assign empty  = (count_q == '0);
  assign wr_acc = Write & ~full;
  assign rd_acc = Read & ~empty;

  always_comb begin
    wptr_d     = wptr_q;
    rptr_d     = rptr_q;
    count_d    = count_q;
    overrun_d  = overrun_q | (Write & full);
    underrun_d = underrun_q | (Read & empty);
    rvalid_d   = rd_acc;
    if (wr_acc) wptr_d = wptr_q + 1'b1;
    if (rd_acc) rptr_d = rptr_q + 1'b1;
    case ({wr_acc, rd_acc})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // Throttle decision looks at the upcoming occupancy so Slowrun moves with Count.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_NORMAL:   if (count_d >= HI_C) state_d = ST_THROTTLE;
      ST_THROTTLE: if (count_d <= LO_C) state_d = ST_NORMAL;
      default:     state_d = ST_NORMAL;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_q     <= '0;
      rptr_q     <= '0;
      count_q    <= '0;
      rvalid_q   <= 1'b0;
      overrun_q  <= 1'b0;
      underrun_q <= 1'b0;
      state_q    <= ST_NORMAL;
    end else begin
      wptr_q     <= wptr_d;
      rptr_q     <= rptr_d;
      count_q    <= count_d;
      rvalid_q   <= rvalid_d;
      overrun_q  <= overrun_d;
      underrun_q <= underrun_d;
      state_q    <= state_d;
    end
  end

  rw_buf_mem #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_mem (
    .clk   (clk),
    .rst   (rst),
    .we    (wr_acc),
    .waddr (wptr_q),
    .wdata (WData),
    .re    (rd_acc),
    .raddr (rptr_q),
    .rdata (RData)
  );

  assign RValid   = rvalid_q;
  assign Slowrun  = (state_q == ST_THROTTLE);
  assign Full     = full;
  assign Empty    = empty;
  assign Count    = count_q;
  assign Overrun  = overrun_q;
  assign Underrun = underrun_q;

endmodule

// File: tb/tb_rw_responder.sv
// Bench for rw_responder: directed scenarios then random strobes, checked
// every cycle against a queue-based reference model.
module tb_rw_responder;

  localparam int DATA_W = 8;
  localparam int DEPTH  = 4;
  localparam int HI     = 3;
  localparam int LO     = 1;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              Read = 1'b0;
  logic              Write = 1'b0;
  logic [DATA_W-1:0] WData = '0;
  logic [DATA_W-1:0] RData;
  logic              RValid, Slowrun, Full, Empty, Overrun, Underrun;
  logic [2:0]        Count;

  int total = 0;
  int bad   = 0;

  // Reference model state
  logic [DATA_W-1:0] exp_q[$];
  logic [DATA_W-1:0] m_rdata;
  logic              m_rvalid, m_over, m_under, m_thr;

  always #5 clk = ~clk;

  rw_responder dut (
    .clk      (clk),
    .rst      (rst),
    .Read     (Read),
    .Write    (Write),
    .WData    (WData),
    .RData    (RData),
    .RValid   (RValid),
    .Slowrun  (Slowrun),
    .Full     (Full),
    .Empty    (Empty),
    .Count    (Count),
    .Overrun  (Overrun),
    .Underrun (Underrun)
  );

  initial begin
    #2_000_000;
    $display("FAIL watchdog obs=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    exp_q.delete();
    m_rdata  = '0;
    m_rvalid = 1'b0;
    m_over   = 1'b0;
    m_under  = 1'b0;
    m_thr    = 1'b0;
  endtask

  task automatic model_step(input logic rd, input logic wr, input logic [DATA_W-1:0] d);
    bit was_full, was_empty;
    was_full  = (exp_q.size() == DEPTH);
    was_empty = (exp_q.size() == 0);
    m_rvalid  = 1'b0;
    if (rd && was_empty) m_under = 1'b1;
    if (wr && was_full)  m_over  = 1'b1;
    if (rd && !was_empty) begin
      m_rdata  = exp_q.pop_front();
      m_rvalid = 1'b1;
    end
    if (wr && !was_full) exp_q.push_back(d);
    if (!m_thr && exp_q.size() >= HI)     m_thr = 1'b1;
    else if (m_thr && exp_q.size() <= LO) m_thr = 1'b0;
  endtask

  task automatic check_all();
    check("count",    32'(Count),    32'(exp_q.size()));
    check("full",     32'(Full),     32'(exp_q.size() == DEPTH));
    check("empty",    32'(Empty),    32'(exp_q.size() == 0));
    check("rvalid",   32'(RValid),   32'(m_rvalid));
    check("rdata",    32'(RData),    32'(m_rdata));
    check("slowrun",  32'(Slowrun),  32'(m_thr));
    check("overrun",  32'(Overrun),  32'(m_over));
    check("underrun", 32'(Underrun), 32'(m_under));
  endtask

  // One clock: drive strobes, let the edge happen, update model, compare.
  task automatic cycle(input logic r, input logic rd, input logic wr, input logic [DATA_W-1:0] d);
    rst   = r;
    Read  = rd;
    Write = wr;
    WData = d;
    @(posedge clk);
    if (r) model_reset();
    else   model_step(rd, wr, d);
    #1;
    check_all();
    rst   = 1'b0;
    Read  = 1'b0;
    Write = 1'b0;
  endtask

  initial begin
    int wp;
    model_reset();
    @(negedge clk);

    // Reset then idle
    cycle(1, 0, 0, 8'h00);
    repeat (3) cycle(0, 0, 0, 8'h00);

    // Basic write/read ordering
    cycle(0, 0, 1, 8'h11);
    cycle(0, 0, 1, 8'h22);
    cycle(0, 1, 0, 8'h00);
    cycle(0, 1, 0, 8'h00);
    cycle(0, 0, 0, 8'h00);

    // Fill to Full, overrun, then drain through both thresholds
    for (int i = 0; i < 4; i++) cycle(0, 0, 1, 8'hA0 + 8'(i));
    cycle(0, 0, 1, 8'hFF);
    repeat (4) cycle(0, 1, 0, 8'h00);
    cycle(0, 0, 0, 8'h00);

    // Underrun, then normal traffic with the sticky flag still set
    cycle(0, 1, 0, 8'h00);
    cycle(0, 0, 1, 8'h55);
    cycle(0, 1, 0, 8'h00);
    cycle(0, 0, 0, 8'h00);

    // Wrapped buffer, simultaneous read+write at Count=2
    cycle(1, 0, 0, 8'h00);
    cycle(0, 0, 1, 8'h01);
    cycle(0, 0, 1, 8'h02);
    cycle(0, 0, 1, 8'h03);
    cycle(0, 1, 0, 8'h00);
    cycle(0, 1, 1, 8'h04);
    cycle(0, 1, 1, 8'h05);
    repeat (3) cycle(0, 1, 0, 8'h00);

    // Full + simultaneous read/write, empty + simultaneous read/write
    for (int i = 0; i < 4; i++) cycle(0, 0, 1, 8'hC0 + 8'(i));
    cycle(0, 1, 1, 8'hEE);
    repeat (3) cycle(0, 1, 0, 8'h00);
    cycle(0, 1, 1, 8'h77);
    cycle(0, 1, 0, 8'h00);

    // Reset mid-operation with a Read strobe in the same cycle
    cycle(1, 0, 0, 8'h00);
    for (int i = 0; i < 3; i++) cycle(0, 0, 1, 8'h30 + 8'(i));
    cycle(1, 1, 0, 8'h00);
    cycle(0, 0, 0, 8'h00);

    // Random traffic, write bias alternating to sweep occupancy
    for (int n = 0; n < 600; n++) begin
      wp = ((n / 40) % 2 == 0) ? 70 : 30;
      cycle(($urandom_range(0, 99) == 0),
            ($urandom_range(0, 99) >= wp),
            ($urandom_range(0, 99) < wp),
            8'($urandom));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
